deser_fifo_param: RTL
=====================

Name: deser_fifo_param

Overview:
Single-clock, parametrised serial-to-parallel receiver with an integrated word FIFO. It is the next generation of the fixed 8-bit deserializer + 8-entry queue pair. It shifts in one bit per write_in strobe and assembles DATA_WIDTH-bit words. Each completed word is pushed into a DEPTH-entry FIFO, and words are popped via deq_in. It adds selectable bit order, edge/level dequeue mode, back-pressure on a full FIFO and a sticky overflow flag.

Parameters:
DATA_WIDTH, 8, bits per assembled word (>=2)
DEPTH, 8, FIFO entries (power of 2, >=2)
MSB_FIRST, 1, 1 = first received bit lands in MSB; 0 = first bit lands in LSB
DEQ_EDGE, 1, 1 = pop once per rising edge of deq_in; 0 = pop every cycle deq_in is high
LEN_W, $clog2(DEPTH+1), width of len_out (derived, not overridden)

Ports:
clock_1M  in  1  single system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
data_in  in  1  serial data bit, sampled when write_in=1
write_in  in  1  bit-valid strobe, one bit accepted per cycle high
deq_in  in  1  dequeue request (edge- or level-qualified per DEQ_EDGE)
data_out  out  DATA_WIDTH  FIFO head word; 0 when empty
len_out  out  LEN_W  number of words stored, 0..DEPTH
status_out  out  1  1 = deserializer accepting bits; 0 = completed word stalled on full FIFO
full_out  out  1  len_out==DEPTH
empty_out  out  1  len_out==0
overflow_out  out  1  sticky: a bit was dropped while status_out=0

Behaviour:
- Reset is synchronous and active-high, sampled on clock_1M.
  - Values after reset: data_out=0, len_out=0, status_out=1, full_out=0, empty_out=1, overflow_out=0.
  - Reset discards the partial word: bit counter=0, FSM returns to COLLECT.
  - Reset discards all FIFO contents, including when it arrives mid-word or mid-pop.
- Deserializer FSM:
  - COLLECT: each cycle with write_in=1 shifts data_in into the shift register.
    - MSB_FIRST=1: shift left, new bit enters LSB, so the first bit ends in the MSB.
    - MSB_FIRST=0: shift right, new bit enters MSB, so the first bit ends in the LSB.
    - Bit counter increments per accepted bit.
    - When the DATA_WIDTH-th bit is accepted, the counter resets to 0 and the FSM moves to PUSH.
  - PUSH: attempts a FIFO write.
    - If not full, or if full and a pop occurs in the same cycle, the word is written and the FSM returns to COLLECT.
    - Otherwise the FSM stays in PUSH with status_out=0.
  - status_out = (state==COLLECT) || (state==PUSH && push succeeds this cycle). It is combinational from state and FIFO state.
  - Any write_in=1 while status_out=0: the bit is dropped and overflow_out is set to 1, cleared only by reset.
  - A write_in=1 in the PUSH cycle that succeeds: the bit is accepted as bit 0 of the next word (no bubble required).
- Latency: the last bit is sampled at edge N, the word enters the FIFO at edge N+1, and len_out/data_out reflect it after edge N+1.
- Dequeue:
  - DEQ_EDGE=1: a registered copy of deq_in gives pop = deq_in & ~deq_q. Holding deq_in high for many cycles pops exactly once.
  - DEQ_EDGE=0: pop = deq_in each cycle.
  - Pop on empty is ignored: no pointer move, len_out stays 0.
- FIFO:
  - Circular buffer with wrap-around read/write pointers of $clog2(DEPTH) bits.
  - The count register is separate from the pointers.
  - Simultaneous push and pop: count unchanged, both pointers advance, including when full.
  - data_out is combinational from the memory at the read pointer, gated to 0 when empty.

Decomposition:
- Package deser_pkg: the FSM state enum (COLLECT, PUSH) and the default width/depth constants.
- One natural sub-module, sync_fifo_param:
  - Parameters: DATA_WIDTH, DEPTH.
  - Signals: push, pop, wdata, rdata, count, full, empty.
  - Reused elsewhere in the design.
- Deserializer FSM, shift register and deq edge detector live in the top level.

Test Plan:
- MSB_FIRST=1, bits 0,0,0,1,0,0,0,1 -> one edge after the last bit: len_out=1, data_out=8'h11; one deq_in pulse -> len_out=0, data_out=0, empty_out=1.
- MSB_FIRST=0, same bits -> data_out=8'h88.
- Push 8 words AA,BB,CC,DD,EE,FF,AB,AC -> len_out=8, full_out=1, data_out=AA; then 8 deq pulses -> outputs AA..AC in order, len_out=0.
- While full, send 9th word 9A -> status_out=0 after its last bit; 3 extra bits -> overflow_out=1; one deq pulse -> AA popped, 9A pushed in the same cycle, len_out stays 8, status_out=1, tail word=9A.
- DEQ_EDGE=1, deq_in held high 100 cycles with 3 words stored -> len_out drops 3->2 exactly once; DEQ_EDGE=0 same stimulus -> len_out reaches 0, extra pops ignored.
- Reset asserted after 5 bits with 2 words stored -> len_out=0, status_out=1, overflow_out=0; next 8 bits 0,0,1,1,0,0,1,1 -> data_out=8'h33.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and default sizing for the serial-to-parallel receiver family.
package deser_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PUSH    = 1'b1
  } deser_state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;

endpackage

// File: rtl/sync_fifo_param.sv
// Single-clock circular-buffer FIFO with a separate occupancy counter.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo_param
  import deser_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LEN_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [LEN_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  always_comb begin
    full    = (count == LEN_W'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = empty ? '0 : mem[rd_ptr];
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/deser_fifo_param.sv
// Serial-to-parallel receiver: assembles DATA_WIDTH-bit words from a bit stream
// and queues them in a DEPTH-entry FIFO, stalling and flagging overflow when full.
module deser_fifo_param
  import deser_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int MSB_FIRST  = 1,
  parameter int DEQ_EDGE   = 1,
  parameter int LEN_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clock_1M,
  input  logic                  reset,
  input  logic                  data_in,
  input  logic                  write_in,
  input  logic                  deq_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LEN_W-1:0]      len_out,
  output logic                  status_out,
  output logic                  full_out,
  output logic                  empty_out,
  output logic                  overflow_out
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  deser_state_t          state;
  deser_state_t          state_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  deq_q;
  logic                  pop_req;
  logic                  pop;
  logic                  push_ok;
  logic                  accept;
  logic                  last_bit;

  // Handshake: a bit is taken on any cycle where write_in && status_out; a
  // completed word is handed to the FIFO on the PUSH cycle where push_ok is high.
  always_comb begin
    pop_req    = (DEQ_EDGE != 0) ? (deq_in & ~deq_q) : deq_in;
    pop        = pop_req & ~empty_out;
    push_ok    = (state == PUSH) && (!full_out || pop);
    status_out = (state == COLLECT) || push_ok;
    accept     = write_in && status_out;
    last_bit   = accept && (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    state_next = state;
    case (state)
      COLLECT: if (last_bit) state_next = PUSH;
      PUSH:    if (push_ok)  state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clock_1M) begin
    if (reset) state <= COLLECT;
    else       state <= state_next;
  end

  // The word held in shreg is written on the push cycle even if a new bit
  // shifts in at the same edge; the FIFO captures the pre-shift value.
  always_ff @(posedge clock_1M) begin
    if (reset) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      deq_q        <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      deq_q <= deq_in;
      if (write_in && !status_out) overflow_out <= 1'b1;
      if (accept) begin
        if (MSB_FIRST != 0) shreg <= {shreg[DATA_WIDTH-2:0], data_in};
        else                shreg <= {data_in, shreg[DATA_WIDTH-1:1]};
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  sync_fifo_param #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .LEN_W      (LEN_W)
  ) u_fifo (
    .clk   (clock_1M),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop),
    .wdata (shreg),
    .rdata (data_out),
    .count (len_out),
    .full  (full_out),
    .empty (empty_out)
  );

endmodule
